// File: rtl/phase_sequencer_if.sv
// Control/status bundle between the phase sequencer and the core control logic.
// The slave modport is the sequencer's view; master is the controller's view.
interface phase_sequencer_if #(
    parameter int unsigned NUM_PHASES = 5,
    parameter int unsigned PHASE_W    = 3,
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned CNT_W      = 32
);
    logic                  exec;
    logic                  step_mode;
    logic                  hlt;
    logic                  stall;
    logic                  bp_en;
    logic [ADDR_W-1:0]     bp_addr;
    logic [ADDR_W-1:0]     pc;
    logic [PHASE_W-1:0]    phase;
    logic [NUM_PHASES:0]   phase_oh;
    logic                  running;
    logic                  halted;
    logic                  bp_hit;
    logic                  instr_done;
    logic [CNT_W-1:0]      retired;

    modport master (
        output exec, step_mode, hlt, stall, bp_en, bp_addr, pc,
        input  phase, phase_oh, running, halted, bp_hit, instr_done, retired
    );

    modport slave (
        input  exec, step_mode, hlt, stall, bp_en, bp_addr, pc,
        output phase, phase_oh, running, halted, bp_hit, instr_done, retired
    );
endinterface

// File: rtl/phase_sequencer.sv
// Instruction-phase sequencer: walks phases 1..NUM_PHASES per instruction with
// stall, single-step, PC breakpoint, sticky halt and a retired-instruction count.
module phase_sequencer #(
    parameter int unsigned NUM_PHASES = 5,
    parameter int unsigned PHASE_W    = 3,
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned CNT_W      = 32
) (
    input  logic                clk,
    input  logic                rst,
    phase_sequencer_if.slave    bus
);
    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_t;

    localparam logic [PHASE_W-1:0] LAST_PHASE  = PHASE_W'(NUM_PHASES);
    localparam logic [PHASE_W-1:0] FIRST_PHASE = PHASE_W'(1);

    state_t             state_q, state_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic [CNT_W-1:0]   retired_q, retired_d;
    logic               exec_q, exec_d;
    logic               stop_req_q, stop_req_d;
    logic               halted_q, halted_d;
    logic               bp_hit_q, bp_hit_d;
    logic               first_q, first_d;

    logic exec_rise;
    logic halting;
    logic bp_match;
    logic instr_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            phase_q    <= '0;
            retired_q  <= '0;
            exec_q     <= 1'b0;
            stop_req_q <= 1'b0;
            halted_q   <= 1'b0;
            bp_hit_q   <= 1'b0;
            first_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            retired_q  <= retired_d;
            exec_q     <= exec_d;
            stop_req_q <= stop_req_d;
            halted_q   <= halted_d;
            bp_hit_q   <= bp_hit_d;
            first_q    <= first_d;
        end
    end

    // first_q masks the breakpoint for the instruction right after a start,
    // so resuming at a matching PC executes that instruction.
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        retired_d  = retired_q;
        exec_d     = bus.exec;
        stop_req_d = stop_req_q;
        halted_d   = halted_q;
        bp_hit_d   = bp_hit_q;
        first_d    = first_q;
        instr_done = 1'b0;

        exec_rise = bus.exec & ~exec_q;
        halting   = halted_q | bus.hlt;
        bp_match  = bus.bp_en & (bus.pc == bus.bp_addr) & ~first_q;

        case (state_q)
            ST_IDLE: begin
                if (exec_rise && !halted_q) begin
                    state_d    = ST_RUN;
                    phase_d    = FIRST_PHASE;
                    bp_hit_d   = 1'b0;
                    stop_req_d = 1'b0;
                    first_d    = 1'b1;
                end
            end
            ST_RUN: begin
                if (bus.hlt) begin
                    halted_d = 1'b1;
                end
                if (exec_rise) begin
                    stop_req_d = 1'b1;
                end
                if (!bus.stall) begin
                    if (phase_q == LAST_PHASE) begin
                        instr_done = 1'b1;
                        retired_d  = retired_q + CNT_W'(1);
                        first_d    = 1'b0;
                        if (halting || stop_req_q || exec_rise ||
                            bus.step_mode || bp_match) begin
                            state_d  = ST_IDLE;
                            phase_d  = '0;
                            bp_hit_d = bp_match & ~halting;
                        end else begin
                            phase_d = FIRST_PHASE;
                        end
                    end else begin
                        phase_d = phase_q + PHASE_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                phase_d = '0;
            end
        endcase
    end

    always_comb begin
        bus.phase_oh          = '0;
        bus.phase_oh[phase_q] = 1'b1;
    end

    assign bus.phase      = phase_q;
    assign bus.running    = (phase_q != '0);
    assign bus.halted     = halted_q;
    assign bus.bp_hit     = bp_hit_q;
    assign bus.instr_done = instr_done;
    assign bus.retired    = retired_q;
endmodule

// File: tb/tb_phase_sequencer.sv
// Directed bench for phase_sequencer: per-cycle expectations are queued as
// stimulus is planned and popped/compared while the sequencer runs.
module tb_phase_sequencer;
    localparam int unsigned NP = 5;

    typedef struct {
        logic [2:0]  phase;
        logic        done;
        logic        bp;
        logic        hlt;
        logic [31:0] ret;
    } exp_t;

    logic clk;
    logic rst;
    int   pass_cnt;
    int   total_cnt;
    int   exp_ret;
    string cur;
    exp_t sb_q[$];

    phase_sequencer_if #(
        .NUM_PHASES(NP),
        .PHASE_W(3),
        .ADDR_W(16),
        .CNT_W(32)
    ) bus ();

    phase_sequencer #(
        .NUM_PHASES(NP),
        .PHASE_W(3),
        .ADDR_W(16),
        .CNT_W(32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #20000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "bench timed out");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int p, input bit d, input bit bp, input bit h);
        exp_t e;
        e.phase = 3'(p);
        e.done  = d;
        e.bp    = bp;
        e.hlt   = h;
        e.ret   = 32'(exp_ret);
        sb_q.push_back(e);
        if (d) exp_ret++;
    endtask

    task automatic push_instr(input int first, input bit bp, input bit h);
        for (int p = first; p <= NP; p++) push(p, (p == NP), bp, h);
    endtask

    task automatic drain();
        exp_t e;
        logic [5:0] oh;
        while (sb_q.size() > 0) begin
            #1;
            e  = sb_q.pop_front();
            oh = 6'b1 << e.phase;
            chk({cur, ".phase"},      64'(bus.phase),      64'(e.phase));
            chk({cur, ".phase_oh"},   64'(bus.phase_oh),   64'(oh));
            chk({cur, ".running"},    64'(bus.running),    64'(e.phase != 3'd0));
            chk({cur, ".instr_done"}, 64'(bus.instr_done), 64'(e.done));
            chk({cur, ".bp_hit"},     64'(bus.bp_hit),     64'(e.bp));
            chk({cur, ".halted"},     64'(bus.halted),     64'(e.hlt));
            chk({cur, ".retired"},    64'(bus.retired),    64'(e.ret));
            @(negedge clk);
        end
    endtask

    task automatic clear_inputs();
        bus.exec      = 1'b0;
        bus.step_mode = 1'b0;
        bus.hlt       = 1'b0;
        bus.stall     = 1'b0;
        bus.bp_en     = 1'b0;
        bus.bp_addr   = '0;
        bus.pc        = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        #1;
        chk("reset.phase",      64'(bus.phase),      64'd0);
        chk("reset.phase_oh",   64'(bus.phase_oh),   64'd1);
        chk("reset.running",    64'(bus.running),    64'd0);
        chk("reset.halted",     64'(bus.halted),     64'd0);
        chk("reset.bp_hit",     64'(bus.bp_hit),     64'd0);
        chk("reset.instr_done", 64'(bus.instr_done), 64'd0);
        chk("reset.retired",    64'(bus.retired),    64'd0);
        @(negedge clk);
        rst     = 1'b0;
        exp_ret = 0;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        exp_ret   = 0;
        rst       = 1'b1;
        clear_inputs();
        @(negedge clk);
        do_reset();

        // Free run of three back-to-back instructions, then stop request in phase 2.
        cur = "free_run";
        bus.exec = 1'b1;
        push(0, 0, 0, 0);
        for (int i = 0; i < 3; i++) push_instr(1, 0, 0);
        drain();
        bus.exec = 1'b0;
        push(1, 0, 0, 0);
        drain();
        cur = "stop_req";
        bus.exec = 1'b1;
        push_instr(2, 0, 0);
        push(0, 0, 0, 0);
        push(0, 0, 0, 0);
        drain();

        // Asynchronous reset in the middle of phase 3.
        cur = "async_rst";
        bus.exec = 1'b0;
        push(0, 0, 0, 0);
        drain();
        bus.exec = 1'b1;
        push(0, 0, 0, 0);
        push(1, 0, 0, 0);
        push(2, 0, 0, 0);
        drain();
        #2;
        chk("async_rst.pre_phase",   64'(bus.phase),   64'd3);
        chk("async_rst.pre_retired", 64'(bus.retired), 64'd4);
        rst = 1'b1;
        #1;
        chk("async_rst.phase",      64'(bus.phase),      64'd0);
        chk("async_rst.running",    64'(bus.running),    64'd0);
        chk("async_rst.phase_oh",   64'(bus.phase_oh),   64'd1);
        chk("async_rst.retired",    64'(bus.retired),    64'd0);
        chk("async_rst.instr_done", 64'(bus.instr_done), 64'd0);
        @(negedge clk);
        bus.exec = 1'b0;
        rst      = 1'b0;
        exp_ret  = 0;

        // Single-step: one instruction per start edge.
        cur = "step";
        bus.step_mode = 1'b1;
        bus.exec      = 1'b1;
        push(0, 0, 0, 0);
        push_instr(1, 0, 0);
        push(0, 0, 0, 0);
        drain();
        bus.exec = 1'b0;
        push(0, 0, 0, 0);
        drain();
        bus.exec = 1'b1;
        push(0, 0, 0, 0);
        push_instr(1, 0, 0);
        push(0, 0, 0, 0);
        push(0, 0, 0, 0);
        drain();

        // Halt raised in phase 2 of the second instruction.
        do_reset();
        cur = "halt";
        bus.exec = 1'b1;
        push(0, 0, 0, 0);
        push_instr(1, 0, 0);
        push(1, 0, 0, 0);
        drain();
        bus.hlt = 1'b1;
        push(2, 0, 0, 0);
        drain();
        bus.hlt = 1'b0;
        push_instr(3, 0, 1);
        push(0, 0, 0, 1);
        push(0, 0, 0, 1);
        drain();
        cur = "halt_ignore";
        bus.exec = 1'b0;
        push(0, 0, 0, 1);
        drain();
        bus.exec = 1'b1;
        for (int i = 0; i < 3; i++) push(0, 0, 0, 1);
        drain();

        // Stalls in last phase and phase 4, breakpoint skipped on first instruction.
        do_reset();
        cur = "stall_bp";
        bus.bp_en   = 1'b1;
        bus.bp_addr = 16'h0010;
        bus.pc      = 16'h0010;
        bus.exec    = 1'b1;
        push(0, 0, 0, 0);
        for (int p = 1; p < NP; p++) push(p, 0, 0, 0);
        drain();
        bus.stall = 1'b1;
        push(5, 0, 0, 0);
        drain();
        bus.stall = 1'b0;
        push(5, 1, 0, 0);
        push(1, 0, 0, 0);
        push(2, 0, 0, 0);
        push(3, 0, 0, 0);
        drain();
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) push(4, 0, 0, 0);
        drain();
        bus.stall = 1'b0;
        push(4, 0, 0, 0);
        push(5, 1, 0, 0);
        push(0, 0, 1, 0);
        drain();
        cur = "bp_resume";
        bus.exec = 1'b0;
        push(0, 0, 1, 0);
        drain();
        bus.exec = 1'b1;
        push(0, 0, 1, 0);
        push_instr(1, 0, 0);
        push_instr(1, 0, 0);
        push(0, 0, 1, 0);
        drain();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
